// File: rtl/alu_seq_pkg.sv
// Shared ALU selection codes, iteration count and FSM state type for alu_sequencer.
// ALU_SEQ_DIV_EN adds the DIV state to the state type.
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0000;

  localparam int         ITER_COUNT = 32;
  localparam logic [4:0] ITER_LAST  = 5'(ITER_COUNT - 1);

`ifdef ALU_SEQ_DIV_EN
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_EXEC = 5'b00010,
    S_MUL  = 5'b00100,
    S_DIV  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_EXEC = 4'b0010,
    S_MUL  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;
`endif

endpackage

// File: rtl/alu_sel_decode.sv
// Combinational mapping of alu_op/funct3/funct7_5 to the shared ALU selection code.
module alu_sel_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_sel
);

  always_comb begin
    alu_sel = ALU_AND;
    case (alu_op)
      2'b00: alu_sel = ALU_ADD;
      2'b01: alu_sel = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b110:  alu_sel = ALU_OR;
          3'b111:  alu_sel = ALU_AND;
          3'b000:  alu_sel = funct7_5 ? ALU_SUB : ALU_ADD;
          default: alu_sel = ALU_AND;
        endcase
      end
      default: alu_sel = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single ALU ops and iterative MUL/DIV onto one shared external ALU.
// Macro ALU_SEQ_DIV_EN compiles in the restoring divider (DIVU/REMU).
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | single-cycle ALU op (or unsupported op, result 0 with error)
// MUL   | 32 shift-add iterations
// DIV   | 32 restoring-divide iterations (ALU_SEQ_DIV_EN only)
// DONE  | response presented until resp_valid && resp_ready
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        is_muldiv,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_err,
  output logic        busy
);

  state_t      state;
  logic [3:0]  dec_sel, sel_q;
  logic [31:0] a_q, b_q, acc_q, res_q;
  logic        err_q;
  logic [4:0]  cnt;
  logic        is_mul, is_div, unsupported;

  alu_sel_decode u_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_sel  (dec_sel)
  );

  assign is_mul = is_muldiv && (funct3 == 3'b000);
`ifdef ALU_SEQ_DIV_EN
  assign is_div = is_muldiv && (funct3 == 3'b101 || funct3 == 3'b111);

  // acc_q holds the partial remainder, a_q shifts the dividend out and the quotient in.
  // A set acc_q[31] means the shifted remainder exceeds 32 bits, so the subtract always fits.
  logic        rem_sel_q, no_borrow;
  logic [31:0] shifted, next_rem, next_quo;
  assign shifted   = {acc_q[30:0], a_q[31]};
  assign no_borrow = acc_q[31] || (shifted >= b_q);
  assign next_rem  = no_borrow ? alu_res : shifted;
  assign next_quo  = {a_q[30:0], no_borrow};
`else
  assign is_div = 1'b0;
`endif
  assign unsupported = is_muldiv && !is_mul && !is_div;

  always_comb begin
    alu_sel = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      S_EXEC: begin
        alu_sel = sel_q;
        alu_a   = a_q;
        alu_b   = b_q;
      end
      S_MUL: begin
        alu_a = acc_q;
        alu_b = b_q[0] ? a_q : '0;
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        alu_sel = ALU_SUB;
        alu_a   = shifted;
        alu_b   = b_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      sel_q       <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      cnt         <= '0;
`ifdef ALU_SEQ_DIV_EN
      rem_sel_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q       <= op_a;
            b_q       <= op_b;
            acc_q     <= '0;
            sel_q     <= dec_sel;
            err_q     <= unsupported;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            rem_sel_q <= funct3[1];
            if (is_mul)      state <= S_MUL;
            else if (is_div) state <= S_DIV;
            else             state <= S_EXEC;
`else
            state <= is_mul ? S_MUL : S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          res_q <= err_q ? '0 : alu_res;
          state <= S_DONE;
        end
        S_MUL: begin
          acc_q <= alu_res;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt   <= cnt + 5'd1;
          if (cnt == ITER_LAST) begin
            res_q <= alu_res;
            state <= S_DONE;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          acc_q <= next_rem;
          a_q   <= next_quo;
          cnt   <= cnt + 5'd1;
          if (cnt == ITER_LAST) begin
            res_q <= rem_sel_q ? next_rem : next_quo;
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          // First DONE cycle publishes the result; it then holds until the handshake.
          if (!resp_valid) begin
            resp_valid  <= 1'b1;
            resp_result <= res_q;
            resp_err    <= err_q;
          end else if (resp_ready) begin
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural model of the shared ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic        is_muldiv = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_muldiv   (is_muldiv),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_sel     (alu_sel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_res     (alu_res),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  // Shared ALU seen by the sequencer.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'b0010: alu_res = alu_a + alu_b;
      4'b0110: alu_res = alu_a - alu_b;
      4'b0001: alu_res = alu_a | alu_b;
      4'b0000: alu_res = alu_a & alu_b;
      default: alu_res = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(input string tag, output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) chk({tag, " timeout"}, 32'(lat), 32'd0);
  endtask

  // Issue one request at a negedge, measure edges from acceptance to resp_valid,
  // check result/error; with hold>0 keep resp_ready low and req_valid high for hold cycles.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic md, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] exp_sel, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_err, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " idle_sel"}, 32'(alu_sel), 32'h2);
    chk({tag, " idle_ab"}, alu_a | alu_b, 32'd0);
    alu_op = op; funct3 = f3; funct7_5 = f7; is_muldiv = md;
    op_a = a; op_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; op_a = 32'hdead_beef; op_b = 32'h1357_9bdf;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " sel"}, 32'(alu_sel), 32'(exp_sel));
    wait_resp(tag, lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, resp_result, exp_res);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    if (hold > 0) begin
      op_a = a; op_b = b; req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, " hold_result"}, resp_result, exp_res);
        chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
        chk({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " post_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " post_busy"}, 32'(busy), 32'd0);
    chk({tag, " post_ready"}, 32'(req_ready), 32'd1);
    if (hold > 0) begin
      // Still-asserted request is taken on the following edge, not on the handshake edge.
      @(posedge clk); #1;
      req_valid = 1'b0; op_a = 32'hdead_beef; op_b = 32'h1357_9bdf;
      chk({tag, " second_busy"}, 32'(busy), 32'd1);
      wait_resp(tag, lat);
      chk({tag, " second_result"}, resp_result, exp_res);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, " second_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_result"}, resp_result, 32'd0);
    chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, " alu_sel"}, 32'(alu_sel), 32'h2);
    chk({tag, " alu_a"}, alu_a, 32'd0);
    chk({tag, " alu_b"}, alu_b, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // First request is accepted on the first rising edge after reset release.
    run_op("rsub",  2'b10, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 4'b0110, 2, 32'd7, 1'b0, 0);
    run_op("add",   2'b00, 3'b101, 1'b1, 1'b0, 32'd5, 32'd7, 4'b0010, 2, 32'd12, 1'b0, 0);
    run_op("sub",   2'b01, 3'b000, 1'b0, 1'b0, 32'd3, 32'd5, 4'b0110, 2, 32'hffff_fffe, 1'b0, 0);
    run_op("or",    2'b10, 3'b110, 1'b0, 1'b0, 32'hf0, 32'h0f, 4'b0001, 2, 32'hff, 1'b0, 0);
    run_op("and",   2'b10, 3'b111, 1'b0, 1'b0, 32'hf0, 32'h3c, 4'b0000, 2, 32'h30, 1'b0, 0);
    run_op("radd",  2'b10, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 4'b0010, 2, 32'd3, 1'b0, 0);
    run_op("rsvd",  2'b11, 3'b000, 1'b0, 1'b0, 32'hf0, 32'h3c, 4'b0000, 2, 32'h30, 1'b0, 0);
    run_op("rf010", 2'b10, 3'b010, 1'b0, 1'b0, 32'hff, 32'h0f, 4'b0000, 2, 32'h0f, 1'b0, 0);
    run_op("mul",   2'b00, 3'b000, 1'b0, 1'b1, 32'h0001_0001, 32'h3, 4'b0010, 33, 32'h0003_0003, 1'b0, 0);
    run_op("mulw",  2'b00, 3'b000, 1'b0, 1'b1, 32'hffff_ffff, 32'h2, 4'b0010, 33, 32'hffff_fffe, 1'b0, 0);
    run_op("mulh",  2'b00, 3'b001, 1'b0, 1'b1, 32'd9, 32'd9, 4'b0010, 2, 32'd0, 1'b1, 0);
`ifdef ALU_SEQ_DIV_EN
    run_op("divu",  2'b00, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 4'b0110, 33, 32'd14, 1'b0, 0);
    run_op("remu",  2'b00, 3'b111, 1'b0, 1'b1, 32'd100, 32'd7, 4'b0110, 33, 32'd2, 1'b0, 0);
    run_op("divu0", 2'b00, 3'b101, 1'b0, 1'b1, 32'd5, 32'd0, 4'b0110, 33, 32'hffff_ffff, 1'b0, 0);
    run_op("remu0", 2'b00, 3'b111, 1'b0, 1'b1, 32'd5, 32'd0, 4'b0110, 33, 32'd5, 1'b0, 0);
`else
    run_op("divu",  2'b00, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 4'b0010, 2, 32'd0, 1'b1, 0);
    run_op("remu",  2'b00, 3'b111, 1'b0, 1'b1, 32'd100, 32'd7, 4'b0010, 2, 32'd0, 1'b1, 0);
`endif
    run_op("hold",  2'b00, 3'b000, 1'b0, 1'b0, 32'd20, 32'd22, 4'b0010, 2, 32'd42, 1'b0, 5);

    // Reset in the middle of a multiply, then a clean multiply.
    @(negedge clk);
    alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; is_muldiv = 1'b1;
    op_a = 32'h0000_0005; op_b = 32'hffff_ffff; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midmul busy", 32'(busy), 32'd1);
    chk("midmul alu_a", 32'(alu_a != 32'd0), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midmul_rst");
    @(negedge clk);
    rst = 1'b0;
    run_op("mul2",  2'b00, 3'b000, 1'b0, 1'b1, 32'h1234, 32'h10, 4'b0010, 33, 32'h1_2340, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
